// File: rtl/imem_if.sv
// Fetch request/response bus between the fetch unit (master) and the
// instruction-memory responder (slave).
interface imem_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency read pipeline feeding a response
// FIFO, credit-limited so the FIFO can never overflow, plus a program-load port.
module imem_responder #(
  parameter int DEPTH_WORDS    = 1024,
  parameter int LATENCY        = 2,
  parameter int RSP_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  imem_if.slave       bus,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_data,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(RSP_FIFO_DEPTH);
  localparam logic [PW:0] CREDITS = (PW+1)'(RSP_FIFO_DEPTH);

  logic [31:0]         mem_r [DEPTH_WORDS];
  logic                run_r;
  logic [PW:0]         outstanding_r;
  logic [LATENCY-1:0]  pipe_vld_r;
  logic [LATENCY-1:0]  pipe_err_r;
  logic [31:0]         pipe_data_r [LATENCY];
  logic [31:0]         fifo_data_r [RSP_FIFO_DEPTH];
  logic [RSP_FIFO_DEPTH-1:0] fifo_err_r;
  logic [PW:0]         wr_ptr_r;
  logic [PW:0]         rd_ptr_r;

  logic        accept_s;
  logic        pop_s;
  logic        push_s;
  logic        req_err_s;
  logic [31:0] rd_word_s;

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) | (|a[31:AW+2]);
  endfunction

  // run_r keeps req_ready low until the first edge after reset release.
  assign bus.req_ready = run_r & ~prog_we & (outstanding_r < CREDITS);
  assign accept_s      = bus.req_valid & bus.req_ready;
  assign pop_s         = bus.rsp_valid & bus.rsp_ready;
  assign push_s        = pipe_vld_r[LATENCY-1];
  assign req_err_s     = addr_bad(bus.req_addr);
  assign rd_word_s     = mem_r[bus.req_addr[AW+1:2]];

  assign bus.rsp_valid = (wr_ptr_r != rd_ptr_r);
  assign bus.rsp_data  = bus.rsp_valid ? fifo_data_r[rd_ptr_r[PW-1:0]] : 32'h0000_0000;
  assign bus.rsp_err   = bus.rsp_valid ? fifo_err_r[rd_ptr_r[PW-1:0]] : 1'b0;
  assign busy          = (outstanding_r != {(PW+1){1'b0}});

  // Program-load write; memory contents survive reset.
  always_ff @(posedge clk) begin
    if (prog_we && !addr_bad(prog_addr)) begin
      mem_r[prog_addr[AW+1:2]] <= prog_data;
    end
  end

  // Run flag releasing req_ready after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
    end
  end

  // Read pipeline: stage 0 captures the memory read, later stages just delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_r <= {LATENCY{1'b0}};
      pipe_err_r <= {LATENCY{1'b0}};
      for (int i = 0; i < LATENCY; i++) begin
        pipe_data_r[i] <= 32'h0000_0000;
      end
    end else begin
      pipe_vld_r[0]  <= accept_s;
      pipe_err_r[0]  <= req_err_s;
      pipe_data_r[0] <= req_err_s ? 32'h0000_0000 : rd_word_s;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld_r[i]  <= pipe_vld_r[i-1];
        pipe_err_r[i]  <= pipe_err_r[i-1];
        pipe_data_r[i] <= pipe_data_r[i-1];
      end
    end
  end

  // Response FIFO; the extra pointer bit separates full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {(PW+1){1'b0}};
      rd_ptr_r   <= {(PW+1){1'b0}};
      fifo_err_r <= {RSP_FIFO_DEPTH{1'b0}};
      for (int i = 0; i < RSP_FIFO_DEPTH; i++) begin
        fifo_data_r[i] <= 32'h0000_0000;
      end
    end else begin
      if (push_s) begin
        fifo_data_r[wr_ptr_r[PW-1:0]] <= pipe_data_r[LATENCY-1];
        fifo_err_r[wr_ptr_r[PW-1:0]]  <= pipe_err_r[LATENCY-1];
        wr_ptr_r <= wr_ptr_r + (PW+1)'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + (PW+1)'(1);
      end
    end
  end

  // Credit counter: requests in the pipeline plus entries in the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_r <= {(PW+1){1'b0}};
    end else begin
      case ({accept_s, pop_s})
        2'b10:   outstanding_r <= outstanding_r + (PW+1)'(1);
        2'b01:   outstanding_r <= outstanding_r - (PW+1)'(1);
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: table of address cases, hand-written
// corner sequences, and a random run against a queue-based reference model.
module tb_imem_responder;
  localparam int LAT = 2;
  localparam int FD  = 4;
  localparam int DW  = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prog_we = 1'b0;
  logic [31:0] prog_addr = 32'h0;
  logic [31:0] prog_data = 32'h0;
  logic        busy;

  imem_if bus();

  imem_responder #(.DEPTH_WORDS(DW), .LATENCY(LAT), .RSP_FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } vec_t;

  rsp_t        q[$];
  logic [31:0] mmem [DW];
  int          edge_n = 0;
  bit          live = 1'b0;
  int          total = 0;
  int          bad = 0;

  function automatic logic [31:0] pat(input int i);
    return (32'(i) * 32'h0100_0193) ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return live && !prog_we && (q.size() < FD);
  endfunction

  function automatic bit m_valid();
    return (q.size() > 0) && (q[0].due <= edge_n);
  endfunction

  task automatic settle_check();
    #1;
    chk("req_ready", 32'(bus.req_ready), 32'(m_ready()));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid()));
    chk("busy", 32'(busy), 32'(q.size() != 0));
    if (m_valid()) begin
      chk("rsp_data", bus.rsp_data, q[0].data);
      chk("rsp_err", 32'(bus.rsp_err), 32'(q[0].err));
    end
    if (!rst_n) begin
      chk("rst_data", bus.rsp_data, 32'h0);
      chk("rst_err", 32'(bus.rsp_err), 32'h0);
    end
  endtask

  task automatic clock_step();
    bit acc, pop, pw;
    logic [31:0] a, pa, pd;
    rsp_t r;
    acc = bus.req_valid && m_ready();
    pop = m_valid() && bus.rsp_ready;
    a = bus.req_addr; pw = prog_we; pa = prog_addr; pd = prog_data;
    @(posedge clk);
    edge_n++;
    if (pop) void'(q.pop_front());
    if (acc) begin
      r.err  = (a % 4 != 0) || (a >= 32'(DW * 4));
      r.data = r.err ? 32'h0 : mmem[a / 4];
      r.due  = edge_n + LAT;
      q.push_back(r);
    end
    if (pw && (pa % 4 == 0) && (pa < 32'(DW * 4))) mmem[pa / 4] = pd;
    live = rst_n;
    #1;
  endtask

  task automatic cyc();
    settle_check();
    clock_step();
  endtask

  task automatic prog(input logic [31:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    cyc();
    prog_we = 1'b0;
  endtask

  task automatic expect_rsp(input string name, input logic [31:0] a,
                            input logic [31:0] d, input logic e);
    bit got;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    settle_check();
    chk({name, "_accept"}, 32'(bus.req_ready), 32'h1);
    clock_step();
    bus.req_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      settle_check();
      if (bus.rsp_valid) begin
        chk({name, "_data"}, bus.rsp_data, d);
        chk({name, "_err"}, 32'(bus.rsp_err), 32'(e));
        got = 1'b1;
      end
      clock_step();
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL %s_timeout: got no response want one", name);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[7];
    int n, sent;

    bus.req_valid = 1'b0; bus.req_addr = 32'h0; bus.rsp_ready = 1'b0;
    for (int i = 0; i < DW; i++) mmem[i] = 32'hx;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < DW; i++) prog(32'(i * 4), pat(i));
    prog(32'h0, 32'h0000_0013);
    prog(32'h4, 32'h0050_0093);

    // Back-to-back fetch: responses appear exactly LAT edges after accept.
    bus.rsp_ready = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 32'h0;
    settle_check(); chk("b2b_ready0", 32'(bus.req_ready), 32'h1);
    clock_step();
    bus.req_addr = 32'h4;
    settle_check(); chk("b2b_ready1", 32'(bus.req_ready), 32'h1);
    clock_step();
    bus.req_valid = 1'b0;
    settle_check(); chk("b2b_early", 32'(bus.rsp_valid), 32'h0);
    clock_step();
    settle_check();
    chk("b2b_v0", 32'(bus.rsp_valid), 32'h1);
    chk("b2b_d0", bus.rsp_data, 32'h0000_0013);
    chk("b2b_e0", 32'(bus.rsp_err), 32'h0);
    clock_step();
    settle_check();
    chk("b2b_d1", bus.rsp_data, 32'h0050_0093);
    clock_step();
    repeat (2) cyc();

    // Back-pressure: only FD requests accepted while nothing drains.
    bus.rsp_ready = 1'b0; bus.req_valid = 1'b1; n = 0;
    for (int k = 0; k < 6; k++) begin
      bus.req_addr = 32'h10 + 32'(4 * k);
      settle_check();
      if (bus.req_ready) n++;
      clock_step();
    end
    bus.req_valid = 1'b0;
    chk("bp_accepts", 32'(n), 32'd4);
    settle_check();
    chk("bp_ready_low", 32'(bus.req_ready), 32'h0);
    chk("bp_busy", 32'(busy), 32'h1);
    bus.rsp_ready = 1'b1;
    clock_step();
    settle_check();
    chk("bp_ready_after_pop", 32'(bus.req_ready), 32'h1);
    clock_step();
    repeat (6) cyc();

    // Address-check table.
    vt[0] = '{32'h0000_0002, 32'h0, 1'b1};
    vt[1] = '{32'h0000_1000, 32'h0, 1'b1};
    vt[2] = '{32'h0000_0004, 32'h0050_0093, 1'b0};
    vt[3] = '{32'h0000_0000, 32'h0000_0013, 1'b0};
    vt[4] = '{32'h0000_0FFC, pat(1023), 1'b0};
    vt[5] = '{32'hFFFF_FFFC, 32'h0, 1'b1};
    vt[6] = '{32'h0000_0803, 32'h0, 1'b1};
    for (int i = 0; i < 7; i++) expect_rsp($sformatf("vec%0d", i), vt[i].addr, vt[i].data, vt[i].err);

    // Program load blocks the request port for that cycle only.
    bus.rsp_ready = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 32'h8;
    prog_we = 1'b1; prog_addr = 32'h8; prog_data = 32'hDEAD_BEEF;
    settle_check(); chk("prog_blocks_ready", 32'(bus.req_ready), 32'h0);
    clock_step();
    prog_we = 1'b0; bus.req_valid = 1'b0;
    expect_rsp("prog_new", 32'h8, 32'hDEAD_BEEF, 1'b0);
    prog(32'h9, 32'h1111_1111);
    prog(32'h1008, 32'h2222_2222);
    expect_rsp("prog_ignored", 32'h8, 32'hDEAD_BEEF, 1'b0);

    // Asynchronous reset with requests in flight.
    bus.rsp_ready = 1'b0; bus.req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.req_addr = 32'(4 * (k + 20));
      cyc();
    end
    bus.req_valid = 1'b0;
    #2;
    rst_n = 1'b0; q.delete(); live = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    expect_rsp("post_reset", 32'h0, 32'h0000_0013, 1'b0);

    // Random sequential requests with random stalls.
    sent = 0;
    for (int c = 0; c < 20000 && sent < 1000; c++) begin
      bus.req_valid = ($urandom_range(0, 9) < 7);
      bus.req_addr  = 32'((sent % 1100) * 4);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      settle_check();
      if (bus.req_valid && bus.req_ready) sent++;
      clock_step();
    end
    chk("rand_sent", 32'(sent), 32'd1000);
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
    for (int c = 0; c < 20 && q.size() != 0; c++) cyc();
    settle_check();
    chk("drain_busy", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the memory-side end of the fetch request/response interface.
- Accepts word-aligned fetch requests through a valid/ready handshake and returns instruction words after a fixed pipeline latency.
- Buffers responses in an internal FIFO so fetch can apply back-pressure; a credit counter prevents overflow.
- Also has a program-load write port that fills the memory before or between runs.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the memory. Power of two.
- LATENCY, 2: cycles from request accept to FIFO push. Legal range 1..4.
- RSP_FIFO_DEPTH, 4: response FIFO entries. Must be a power of two and at least LATENCY+1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address of the instruction.
- rsp_valid  out  1  response available at the FIFO head.
- rsp_ready  in  1  fetch consumes the response.
- rsp_data  out  32  instruction word at the FIFO head.
- rsp_err  out  1  FIFO-head request was misaligned or out of range.
- prog_we  in  1  program-load write enable.
- prog_addr  in  32  byte address for the program-load write.
- prog_data  in  32  word to write.
- busy  out  1  at least one request is outstanding (in pipeline or FIFO).

Behaviour:
- Reset (rst_n low, asynchronous): pipeline valids, FIFO pointers and credit counter clear. req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0. Memory contents are not reset. All in-flight requests are dropped, including on reset mid-operation. Outputs leave reset on the first clk edge after rst_n rises.
- Accept rule: a request is accepted on a clk edge where req_valid & req_ready.
  - req_ready = !prog_we & (outstanding < RSP_FIFO_DEPTH).
  - req_ready is combinational from prog_we and registered state; it never depends on req_valid.
- Outstanding counter, width clog2(RSP_FIFO_DEPTH)+1:
  - +1 on accept; -1 on pop (rsp_valid & rsp_ready); unchanged when both occur in the same cycle.
  - busy = (outstanding != 0).
- Address check at accept:
  - err = (req_addr[1:0] != 0) | (req_addr[31:2] >= DEPTH_WORDS).
  - On err, the response carries data 32'h0 and err=1.
  - Otherwise data = mem[req_addr[31:2]] and err=0.
  - Memory is read in the accept cycle (stage 0); {data, err} is carried through LATENCY-1 further register stages.
- Pipeline and FIFO:
  - Each stage has its own valid bit; the pipeline never stalls.
  - The stage-LATENCY output pushes into the FIFO; credits guarantee space.
  - The FIFO may push and pop in the same cycle, including when full or when the FIFO has one entry.
  - rsp_valid = FIFO not empty. rsp_data and rsp_err reflect the FIFO head and hold stable while rsp_valid & !rsp_ready.
  - Responses return in request order.
- Timing:
  - Request accepted at edge T with an empty FIFO gives rsp_valid=1 after edge T+LATENCY.
  - With rsp_ready held high, throughput is 1 response per cycle indefinitely.
- Program load: when prog_we=1, mem[prog_addr[31:2]] <= prog_data at the clk edge.
  - The write is ignored if prog_addr is misaligned or out of range; no error is reported.
  - prog_we=1 forces req_ready=0, so a read and a write never share a cycle.
  - Requests already in flight complete with the data read at their accept.
- Wrap-around: FIFO pointers wrap modulo RSP_FIFO_DEPTH. Full and empty are distinguished by the extra pointer bit.

Test Plan:
- Load 0x00000013 at byte 0x0 and 0x00500093 at 0x4; request 0x0 then 0x4 back-to-back with rsp_ready=1. Required: req_ready high both cycles; rsp_data=0x00000013 at T+2, 0x00500093 at T+3; rsp_err=0.
- rsp_ready=0, issue 6 requests. Required: exactly 4 accepted, then req_ready=0 and busy=1. Raise rsp_ready: responses drain in order and req_ready returns high the cycle after the first pop.
- Request 0x2 and 0x1000 (DEPTH_WORDS=1024). Required: both responses have rsp_err=1 and rsp_data=0. A following request to 0x4 returns valid data with rsp_err=0.
- Assert prog_we with req_valid high. Required: req_ready=0 for that cycle and no accept. Next cycle the request to the just-written address returns the new data.
- With 3 requests outstanding, pull rst_n low mid-cycle. Required: rsp_valid, busy and req_ready go 0 immediately. After release, the first request returns correct data with no stale responses.
- Run 1000 sequential requests with random rsp_ready stalls and compare against a model. Required: no loss, no duplication, no reordering, and rsp_data stable whenever the handshake is stalled.
